// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states
// and the sizing helpers used by the datapath.
package mdu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  // Counter must hold 0..S_DATA-1 with headroom, hence one bit over clog2.
  function automatic int iter_width(input int s_data);
    return $clog2(s_data) + 1;
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op <= OP_MTLO);
  endfunction

  function automatic logic op_is_long(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/mult_div_hilo_if.sv
// Issue/result bundle between the execute stage and the HI/LO unit.
interface mult_div_hilo_if
  import mdu_pkg::*;
#(
  parameter int S_DATA = DATA_W
);

  logic              Start;
  logic [2:0]        Op;
  logic [S_DATA-1:0] OpA;
  logic [S_DATA-1:0] OpB;
  logic              Busy;
  logic              Done;
  logic              DivZero;
  logic [S_DATA-1:0] Hi;
  logic [S_DATA-1:0] Lo;

  modport master (
    output Start, Op, OpA, OpB,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, OpA, OpB,
    output Busy, Done, DivZero, Hi, Lo
  );

endinterface

// File: rtl/mult_div_hilo.sv
// Iterative MIPS32 multiply/divide unit with architectural HI/LO registers.
// One shared (S_DATA+1)-bit adder serves both shift-add multiply and restoring divide.
module mult_div_hilo
  import mdu_pkg::*;
#(
  parameter int S_DATA = DATA_W
) (
  input logic             clk,
  input logic             rst_n,
  mult_div_hilo_if.slave  bus
);

  localparam int CNT_W = iter_width(S_DATA);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(S_DATA - 1);

  state_e state, next_state;

  logic [2*S_DATA-1:0] acc;
  logic [S_DATA-1:0]   opnd;
  logic [S_DATA-1:0]   raw_a;
  logic [S_DATA-1:0]   hi;
  logic [S_DATA-1:0]   lo;
  logic [CNT_W-1:0]    count;
  logic                is_div;
  logic                neg_lo;
  logic                neg_hi;
  logic                div_zero;

  logic                busy;
  logic                accept;
  logic                signed_op;
  logic                div_op;
  logic                msb_a;
  logic                msb_b;
  logic [S_DATA-1:0]   a_mag;
  logic [S_DATA-1:0]   b_mag;

  logic [S_DATA-1:0]   acc_hi;
  logic [S_DATA-1:0]   acc_lo;
  logic [S_DATA:0]     add_x;
  logic [S_DATA:0]     add_y;
  logic [S_DATA:0]     sum;
  logic [2*S_DATA-1:0] acc_next;
  logic [2*S_DATA-1:0] prod;
  logic [S_DATA-1:0]   fix_hi;
  logic [S_DATA-1:0]   fix_lo;

  assign busy   = (state == ST_CALC) || (state == ST_FIX);
  assign accept = bus.Start && !busy && op_is_valid(bus.Op);

  // Operand decode at issue: signed ops work on magnitudes and remember the signs.
  always_comb begin
    signed_op = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    div_op    = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
    msb_a     = bus.OpA[S_DATA-1];
    msb_b     = bus.OpB[S_DATA-1];
    a_mag     = (signed_op && msb_a) ? -bus.OpA : bus.OpA;
    b_mag     = (signed_op && msb_b) ? -bus.OpB : bus.OpB;
  end

  // Shared adder: multiply adds the multiplicand into the high half,
  // divide subtracts the divisor from the shifted partial remainder.
  always_comb begin
    acc_hi = acc[2*S_DATA-1:S_DATA];
    acc_lo = acc[S_DATA-1:0];
    if (is_div) begin
      add_x = {acc_hi, acc_lo[S_DATA-1]};
      add_y = ~{1'b0, opnd};
    end else begin
      add_x = {1'b0, acc_hi};
      add_y = acc_lo[0] ? {1'b0, opnd} : '0;
    end
    sum = add_x + add_y + (S_DATA+1)'(is_div);

    if (!is_div)
      acc_next = {sum, acc_lo[S_DATA-1:1]};
    else if (sum[S_DATA])
      acc_next = {add_x[S_DATA-1:0], acc_lo[S_DATA-2:0], 1'b0};
    else
      acc_next = {sum[S_DATA-1:0], acc_lo[S_DATA-2:0], 1'b1};
  end

  // Sign correction and divide-by-zero substitution applied on the FIX edge.
  always_comb begin
    prod = neg_lo ? -acc : acc;
    if (is_div) begin
      fix_lo = div_zero ? '1    : (neg_lo ? -acc_lo : acc_lo);
      fix_hi = div_zero ? raw_a : (neg_hi ? -acc_hi : acc_hi);
    end else begin
      fix_hi = prod[2*S_DATA-1:S_DATA];
      fix_lo = prod[S_DATA-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)
          next_state = op_is_long(bus.Op) ? ST_CALC : ST_DONE;
        else
          next_state = ST_IDLE;
      end
      ST_CALC: begin
        if (count == LAST_ITER)
          next_state = ST_FIX;
      end
      ST_FIX:  next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd     <= '0;
      raw_a    <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (accept) begin
      if (bus.Op == OP_MTHI) begin
        hi       <= bus.OpA;
        div_zero <= 1'b0;
      end else if (bus.Op == OP_MTLO) begin
        lo       <= bus.OpA;
        div_zero <= 1'b0;
      end else begin
        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
        acc      <= {{S_DATA{1'b0}}, (div_op ? a_mag : b_mag)};
        opnd     <= div_op ? b_mag : a_mag;
        raw_a    <= bus.OpA;
        count    <= '0;
        is_div   <= div_op;
        neg_lo   <= signed_op && (msb_a ^ msb_b);
        neg_hi   <= signed_op && div_op && msb_a;
        div_zero <= div_op && (bus.OpB == '0);
      end
    end else if (state == ST_CALC) begin
      acc   <= acc_next;
      count <= count + CNT_W'(1);
    end else if (state == ST_FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end

  assign bus.Busy    = busy;
  assign bus.Done    = (state == ST_DONE);
  assign bus.DivZero = (state == ST_DONE) && div_zero;
  assign bus.Hi      = hi;
  assign bus.Lo      = lo;

endmodule
